// File: rtl/branch_target_predictor.sv
// Fetch-stage direct-mapped branch target buffer with 2-bit saturating direction
// counters, zero-latency lookup, resolved-branch training and hit/mispredict statistics.
module branch_target_predictor #(
   parameter int INDEX_BITS = 4,
   parameter int STAT_WIDTH = 16
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic [31:0]           iPCF,
   output logic                  oPCSrcF,
   output logic [31:0]           oBranchTarget,
   input  logic                  iUpdateEn,
   input  logic [31:0]           iUpdatePC,
   input  logic                  iUpdateTaken,
   input  logic [31:0]           iUpdateTarget,
   input  logic                  iMispredict,
   input  logic                  iFlush,
   output logic [STAT_WIDTH-1:0] oHitCount,
   output logic [STAT_WIDTH-1:0] oMispredictCount
);

   localparam int TAG_BITS = 32 - INDEX_BITS - 2;
   localparam int ENTRIES  = 1 << INDEX_BITS;

   logic [ENTRIES-1:0]  valid_q;
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];

   logic [STAT_WIDTH-1:0] hit_cnt_q;
   logic [STAT_WIDTH-1:0] mispredict_cnt_q;

   logic [INDEX_BITS-1:0] look_idx;
   logic [TAG_BITS-1:0]   look_tag;
   logic                  look_hit;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [TAG_BITS-1:0]   upd_tag;
   logic                  upd_hit;
   logic [31:0]           upd_target;
   logic                  unused_lsbs;

   assign look_idx = iPCF[INDEX_BITS+1:2];
   assign look_tag = iPCF[31:INDEX_BITS+2];
   assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);

   assign upd_idx    = iUpdatePC[INDEX_BITS+1:2];
   assign upd_tag    = iUpdatePC[31:INDEX_BITS+2];
   assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign upd_target = {iUpdateTarget[31:2], 2'b00};

   // Low PC bits never select an entry; targets are always word aligned.
   assign unused_lsbs = ^{iUpdatePC[1:0], iUpdateTarget[1:0]};

   // Lookup reads pre-update storage: a same-cycle update is visible next cycle.
   assign oPCSrcF          = look_hit && ctr_q[look_idx][1];
   assign oBranchTarget    = look_hit ? target_q[look_idx] : iPCF + 32'd4;
   assign oHitCount        = hit_cnt_q;
   assign oMispredictCount = mispredict_cnt_q;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         valid_q          <= '0;
         hit_cnt_q        <= '0;
         mispredict_cnt_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else begin
         if (look_hit)
            hit_cnt_q <= hit_cnt_q + STAT_WIDTH'(1);
         if (iUpdateEn && iMispredict)
            mispredict_cnt_q <= mispredict_cnt_q + STAT_WIDTH'(1);

         // Flush drops any update presented on the same edge.
         if (iFlush) begin
            valid_q <= '0;
         end else if (iUpdateEn) begin
            if (upd_hit) begin
               if (iUpdateTaken) begin
                  ctr_q[upd_idx]    <= (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
                  target_q[upd_idx] <= upd_target;
               end else begin
                  ctr_q[upd_idx] <= (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
               end
            end else if (iUpdateTaken) begin
               valid_q[upd_idx]  <= 1'b1;
               tag_q[upd_idx]    <= upd_tag;
               target_q[upd_idx] <= upd_target;
               ctr_q[upd_idx]    <= 2'b10;
            end
         end
      end
   end

endmodule
